// File: rtl/fmul_issue.sv
// Issue stage for an external FP multiplier: operand FIFO, single-in-flight
// issue FSM with a WAIT watchdog, and a held result register for downstream.
module fmul_issue #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_x1,
  input  logic [31:0]              in_x2,
  input  logic [TAG_W-1:0]         in_tag,
  output logic [31:0]              mul_x1,
  output logic [31:0]              mul_x2,
  output logic                     mul_ready,
  input  logic                     mul_valid,
  input  logic [31:0]              mul_y,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_y,
  output logic [TAG_W-1:0]         out_tag,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err,
  output logic                     busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [31:0]       x1_q, x1_d, x2_q, x2_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [31:0]       y_q, y_d;
  logic [TAG_W-1:0]  otag_q, otag_d;
  logic              out_valid_q, out_valid_d;
  logic              mul_ready_q, mul_ready_d;
  logic              err_q, err_d;
  logic [2:0]        wcnt_q, wcnt_d;

  logic [31:0]       mem_x1  [DEPTH];
  logic [31:0]       mem_x2  [DEPTH];
  logic [TAG_W-1:0]  mem_tag [DEPTH];

  logic push, pop;

  assign in_ready = (count_q != CW'(DEPTH));
  assign push     = in_valid && in_ready;
  // A new operation only leaves the FIFO once the previous result has been taken.
  assign pop      = (state_q == IDLE) && (count_q != '0) && !out_valid_q;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_x1[wr_ptr_q]  <= in_x1;
      mem_x2[wr_ptr_q]  <= in_x2;
      mem_tag[wr_ptr_q] <= in_tag;
    end
  end

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    x1_d        = x1_q;
    x2_d        = x2_q;
    tag_d       = tag_q;
    y_d         = y_q;
    otag_d      = otag_q;
    out_valid_d = out_valid_q;
    err_d       = err_q;
    wcnt_d      = wcnt_q;

    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
      x1_d     = mem_x1[rd_ptr_q];
      x2_d     = mem_x2[rd_ptr_q];
      tag_d    = mem_tag[rd_ptr_q];
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (mul_valid) err_d = 1'b1;
        if (pop) state_d = ISSUE;
      end
      ISSUE: begin
        if (mul_valid) err_d = 1'b1;
        wcnt_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (mul_valid) begin
          y_d         = mul_y;
          otag_d      = tag_q;
          out_valid_d = 1'b1;
          state_d     = IDLE;
        end else if (wcnt_q == 3'd7) begin
          // Multiplier never answered: drop the operation and flag it.
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          wcnt_d = wcnt_q + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    mul_ready_d = (state_d == ISSUE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      x1_q        <= '0;
      x2_q        <= '0;
      tag_q       <= '0;
      y_q         <= '0;
      otag_q      <= '0;
      out_valid_q <= 1'b0;
      mul_ready_q <= 1'b0;
      err_q       <= 1'b0;
      wcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      x1_q        <= x1_d;
      x2_q        <= x2_d;
      tag_q       <= tag_d;
      y_q         <= y_d;
      otag_q      <= otag_d;
      out_valid_q <= out_valid_d;
      mul_ready_q <= mul_ready_d;
      err_q       <= err_d;
      wcnt_q      <= wcnt_d;
    end
  end

  assign mul_x1    = x1_q;
  assign mul_x2    = x2_q;
  assign mul_ready = mul_ready_q;
  assign out_valid = out_valid_q;
  assign out_y     = y_q;
  assign out_tag   = otag_q;
  assign count     = count_q;
  assign err       = err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_fmul_issue.sv
// Self-checking bench for fmul_issue: behavioural multiplier, result scoreboard,
// occupancy model, vector table plus directed corner-case sequences.
module tb_fmul_issue;

  logic        clk, rst;
  logic        in_valid, in_ready;
  logic [31:0] in_x1, in_x2;
  logic [4:0]  in_tag;
  logic [31:0] mul_x1, mul_x2, mul_y;
  logic        mul_ready, mul_valid;
  logic        out_valid, out_ready;
  logic [31:0] out_y;
  logic [4:0]  out_tag;
  logic [2:0]  count;
  logic        err, busy;

  fmul_issue #(.DEPTH(4), .TAG_W(5)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_x1(in_x1), .in_x2(in_x2), .in_tag(in_tag),
    .mul_x1(mul_x1), .mul_x2(mul_x2), .mul_ready(mul_ready),
    .mul_valid(mul_valid), .mul_y(mul_y),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .out_tag(out_tag),
    .count(count), .err(err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0, n_fail = 0, n_out = 0, mr_cnt = 0, viol = 0;

  // Single-precision multiply for normal/zero operands, truncating.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    logic [47:0] p;
    int          e;
    s = a[31] ^ b[31];
    if (a[30:0] == 31'd0 || b[30:0] == 31'd0) return {s, 31'd0};
    p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) begin
      p = p >> 1;
      e = e + 1;
    end
    return {s, e[7:0], p[45:23]};
  endfunction

  // Multiplier model: mul_valid two full cycles after the ISSUE cycle ends.
  logic [2:0] mpipe;
  logic       hang, spur;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) mpipe <= '0;
    else     mpipe <= {mpipe[1:0], mul_ready & ~hang};
  end
  assign mul_valid = mpipe[2] | spur;
  assign mul_y     = fmul(mul_x1, mul_x2);

  typedef struct packed {
    logic [31:0] y;
    logic [4:0]  tag;
  } exp_t;
  exp_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, req);
    end
  endtask

  // Output scoreboard, occupancy model and mul_ready rules, all sampled at negedge.
  int   cm = 0;
  bit   acc_prev = 0, mr_prev = 0, ov_prev = 0, taken_prev = 0;
  logic [31:0] y_prev;
  logic [4:0]  t_prev;
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      cm = 0; acc_prev = 0; mr_prev = 0; ov_prev = 0; taken_prev = 0;
    end else begin
      cm = cm + int'(acc_prev) - int'(mul_ready);
      n_cmp++;
      if (int'(count) != cm) begin
        n_fail++;
        $display("FAIL count_model: got %0d, want %0d", count, cm);
      end
      acc_prev = in_valid && in_ready;
      if (mul_ready) mr_cnt++;
      if (mul_ready && (out_valid || mr_prev)) viol++;
      mr_prev = mul_ready;
      if (ov_prev && !taken_prev && out_valid) begin
        n_cmp++;
        if (out_y !== y_prev || out_tag !== t_prev) begin
          n_fail++;
          $display("FAIL out_hold: got 0x%08h/%0d, want 0x%08h/%0d", out_y, out_tag, y_prev, t_prev);
        end
      end
      ov_prev = out_valid; taken_prev = out_valid && out_ready;
      y_prev = out_y; t_prev = out_tag;
      if (out_valid && out_ready) begin
        n_out++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_out: got 0x%08h tag %0d, want no output", out_y, out_tag);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (out_y !== e.y || out_tag !== e.tag) begin
            n_fail++;
            $display("FAIL out_data: got 0x%08h tag %0d, want 0x%08h tag %0d", out_y, out_tag, e.y, e.tag);
          end else begin
            $display("OUT #%0d y=0x%08h tag=%0d ok", n_out, out_y, out_tag);
          end
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] x1, input logic [31:0] x2, input logic [4:0] tag,
                      input logic [31:0] y, input bit expect_out);
    bit ok = 0;
    in_valid = 1'b1; in_x1 = x1; in_x2 = x2; in_tag = tag;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        if (expect_out) exp_q.push_back('{y: y, tag: tag});
        $display("IN  x1=0x%08h x2=0x%08h tag=%0d", x1, x2, tag);
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!ok) begin
      n_cmp++; n_fail++;
      $display("FAIL push_timeout: got no in_ready, want accept within 300 cycles");
    end
  endtask

  task automatic wait_drain(input int bound);
    bit ok = 0;
    for (int i = 0; i < bound && !ok; i++) begin
      if (exp_q.size() == 0 && !busy && !out_valid && count == 3'd0) ok = 1;
      else step(1);
    end
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending, want 0 within %0d cycles", exp_q.size(), bound);
    end
  endtask

  function automatic logic [31:0] rnd_op();
    return {1'($urandom_range(0, 1)), 8'($urandom_range(100, 150)), 23'($urandom)};
  endfunction

  typedef struct {
    logic [31:0] x1;
    logic [31:0] x2;
    logic [4:0]  tag;
    logic [31:0] y;
  } vec_t;
  vec_t tbl[5];
  bit   done;

  initial begin
    int lat, mr0, out0;
    logic [31:0] a, b;

    tbl[0] = '{32'h3FC00000, 32'h40000000, 5'd3,  32'h40400000};
    tbl[1] = '{32'hBF800000, 32'h40000000, 5'd7,  32'hC0000000};
    tbl[2] = '{32'h00000000, 32'h40000000, 5'd8,  32'h00000000};
    tbl[3] = '{32'h40400000, 32'h40400000, 5'd31, 32'h41100000};
    tbl[4] = '{32'h3F800000, 32'h3F800000, 5'd0,  32'h3F800000};

    rst = 1'b1; in_valid = 1'b0; in_x1 = '0; in_x2 = '0; in_tag = '0;
    out_ready = 1'b1; hang = 1'b0; spur = 1'b0; done = 0;
    step(3);
    rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mul_ready", 32'(mul_ready), 32'd0);
    chk("rst_mul_x1", mul_x1, 32'd0);
    chk("rst_out_y", out_y, 32'd0);
    step(2);

    // Single op: one mul_ready pulse, out_valid in the 5th cycle after accept.
    mr0 = mr_cnt;
    push(tbl[0].x1, tbl[0].x2, tbl[0].tag, tbl[0].y, 1);
    lat = 0;
    while (!out_valid && lat < 20) begin
      step(1);
      lat++;
    end
    chk("latency_edges", 32'(lat), 32'd5);
    chk("single_out_y", out_y, tbl[0].y);
    wait_drain(50);
    chk("single_mr_pulses", 32'(mr_cnt - mr0), 32'd1);

    // Remaining vectors back to back.
    for (int i = 1; i < 5; i++) push(tbl[i].x1, tbl[i].x2, tbl[i].tag, tbl[i].y, 1);
    wait_drain(200);

    // Backpressure: FIFO fills, sixth entry stalls, then all drain in order.
    out_ready = 1'b0; mr0 = mr_cnt; out0 = n_out;
    for (int i = 1; i <= 5; i++) begin
      a = rnd_op(); b = rnd_op();
      push(a, b, 5'(i), fmul(a, b), 1);
    end
    step(10);
    chk("bp_count_full", 32'(count), 32'd4);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    chk("bp_mr_pulses", 32'(mr_cnt - mr0), 32'd1);
    a = rnd_op(); b = rnd_op();
    in_valid = 1'b1; in_x1 = a; in_x2 = b; in_tag = 5'd6;
    step(3);
    chk("bp_stall_count", 32'(count), 32'd4);
    chk("bp_stall_mr", 32'(mr_cnt - mr0), 32'd1);
    out_ready = 1'b1;
    push(a, b, 5'd6, fmul(a, b), 1);
    wait_drain(200);
    chk("bp_outputs", 32'(n_out - out0), 32'd6);

    // Watchdog: first op dropped after 8 WAIT cycles, next one issues normally.
    hang = 1'b1; out0 = n_out;
    a = rnd_op(); b = rnd_op();
    push(a, b, 5'd9, 32'd0, 0);
    a = rnd_op(); b = rnd_op();
    push(a, b, 5'd10, fmul(a, b), 1);
    lat = 1;
    while (!err && lat < 40) begin
      step(1);
      lat++;
    end
    hang = 1'b0;
    chk("wd_err_edges", 32'(lat), 32'd10);
    chk("wd_busy", 32'(busy), 32'd0);
    chk("wd_out_valid", 32'(out_valid), 32'd0);
    wait_drain(100);
    chk("wd_outputs", 32'(n_out - out0), 32'd1);
    chk("wd_err_sticky", 32'(err), 32'd1);

    // Reset during WAIT with three entries queued.
    hang = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = rnd_op(); b = rnd_op();
      push(a, b, 5'(20 + i), fmul(a, b), 1);
    end
    chk("pre_rst_count", 32'(count), 32'd3);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_err", 32'(err), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    step(2);
    rst = 1'b0; hang = 1'b0; out0 = n_out;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    step(20);
    chk("post_rst_no_out", 32'(n_out - out0), 32'd0);

    // Stray mul_valid while idle sets err.
    spur = 1'b1;
    step(1);
    spur = 1'b0;
    chk("spur_err", 32'(err), 32'd1);
    step(3);
    chk("spur_err_sticky", 32'(err), 32'd1);
    chk("spur_no_out", 32'(out_valid), 32'd0);

    // Full FIFO, then stream enough entries to wrap the pointers three times.
    out_ready = 1'b0; out0 = n_out;
    for (int i = 0; i < 5; i++) begin
      a = rnd_op(); b = rnd_op();
      push(a, b, 5'(i), fmul(a, b), 1);
    end
    step(10);
    chk("wrap_full_count", 32'(count), 32'd4);
    fork
      begin
        for (int i = 0; i < 13; i++) begin
          logic [31:0] p, q;
          p = rnd_op(); q = rnd_op();
          push(p, q, 5'(i + 5), fmul(p, q), 1);
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    wait_drain(300);
    chk("wrap_outputs", 32'(n_out - out0), 32'd18);
    chk("mul_ready_rules", 32'(viol), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: got no finish, want finish before 300000 ns");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fmul_issue.md
FMUL_ISSUE -- requirements
Module: fmul_issue

Interface
REQ-001 SHALL have parameter DEPTH, default 4: operand FIFO depth in entries, power of two, at least 2.
REQ-002 SHALL have parameter TAG_W, default 5: width of the tag carried with each operation.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have ports in_valid (input, 1), in_ready (output, 1), in_x1 (input, 32), in_x2 (input, 32) and in_tag (input, TAG_W): upstream operation request.
REQ-006 SHALL have ports mul_x1 (output, 32) and mul_x2 (output, 32): operands to the multiplier, driven from registers.
REQ-007 SHALL have port mul_ready, output, 1: one-cycle start strobe to the multiplier.
REQ-008 SHALL have ports mul_valid (input, 1) and mul_y (input, 32): multiplier result strobe and result.
REQ-009 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_y (output, 32) and out_tag (output, TAG_W): downstream result.
REQ-010 SHALL have ports count (output, clog2(DEPTH)+1), err (output, 1) and busy (output, 1): FIFO occupancy, sticky fault flag, and "operation in flight".

Function
REQ-011 SHALL accept an entry on a clock edge where in_valid and in_ready are both high; in_ready = (count != DEPTH), combinational from registered count.
REQ-012 SHALL implement the FIFO as a circular buffer with wrapping read/write pointers; a push and a pop on the same edge SHALL leave count unchanged, including when full.
REQ-013 SHALL have a state machine with states IDLE, ISSUE and WAIT.
REQ-014 IDLE->ISSUE when count != 0 and out_valid == 0: on that edge, pop the head entry into the operand registers (mul_x1, mul_x2) and the tag register.
REQ-015 ISSUE: mul_ready = 1 for exactly this cycle; unconditional transition to WAIT.
REQ-016 mul_ready SHALL be 0 in every state other than ISSUE.
REQ-017 mul_x1, mul_x2 and the tag register SHALL hold their values from the ISSUE cycle until the cycle after mul_valid is sampled; the multiplier samples its operands combinationally through its valid cycle.
REQ-018 WAIT: when mul_valid == 1, capture mul_y into out_y and the tag register into out_tag; set out_valid; go to IDLE.
REQ-019 out_valid SHALL remain 1, with out_y and out_tag stable, until an edge with out_ready == 1, which clears it.
REQ-020 At most one operation SHALL be in flight; result order SHALL equal acceptance order.
REQ-021 Nominal latency: the multiplier asserts mul_valid 2 cycles after the ISSUE cycle; first accepted entry into an idle, empty block reaches out_valid = 1 five cycles after the accepting edge.
REQ-022 A WAIT cycle counter SHALL be cleared on entry to WAIT; if 8 WAIT cycles pass without mul_valid, then: set err; discard the operation with no out_valid; return to IDLE.
REQ-023 mul_valid seen in IDLE or ISSUE SHALL be ignored for data purposes and SHALL set err.
REQ-024 err SHALL be sticky until reset.
REQ-025 busy = (state != IDLE).
REQ-026 The block SHALL NOT modify data: no arithmetic on mul_y; the tag SHALL pass through unchanged.

Reset
REQ-027 On rst asserted, asynchronously set: state = IDLE; FIFO pointers and count = 0; out_valid = 0; mul_ready = 0; err = 0; WAIT counter = 0.
REQ-028 On rst, mul_x1, mul_x2, out_y and out_tag SHALL reset to 0.
REQ-029 Reset mid-operation SHALL discard all queued and in-flight entries; the multiplier must be reset in the same window.
REQ-030 in_ready SHALL be 1 in the first cycle after rst deasserts.

Verification
REQ-031 Push in_x1 = 0x3FC00000, in_x2 = 0x40000000, tag 3, out_ready = 1 -> single mul_ready pulse; out_valid 5 cycles after accept; out_y = 0x40400000, out_tag = 3.
REQ-032 Push 0xBF800000 x 0x40000000, then 0x00000000 x 0x40000000, back to back -> results 0xC0000000 then 0x00000000, in that order, tags preserved.
REQ-033 out_ready = 0; push 6 entries (DEPTH = 4) -> entry 1 issues and completes; entries 2-5 fill FIFO; count = 4; in_ready = 0, so entry 6 stalls; no second mul_ready while out_valid = 1; after out_ready = 1, all 5 drain in order.
REQ-034 mul_valid held 0 by the bench model -> err = 1 after the 8th WAIT cycle; state back to IDLE; no out_valid; next queued entry issues normally.
REQ-035 Assert rst during WAIT with 3 entries queued -> count = 0, out_valid = 0, err = 0, busy = 0 immediately; no output appears afterwards.
REQ-036 Simultaneous push and pop at count = DEPTH, then wrap pointers through 3 full cycles -> count stays correct; no entry lost or duplicated.
